// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter; `UART_ARB_LOCK_EN enables message locking
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]          i_req_lock,
  output logic [NUM_REQ-1:0]          o_req_ready,
  output logic [DATA_W-1:0]           o_tx_data,
  output logic                        o_tx_start,
  input  logic                        i_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
  output logic                        o_active,
  output logic                        o_err_timeout
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_ptr, r_grant, w_win, w_ptr_inc;
  logic [CW-1:0] r_cnt;
  logic [DATA_W-1:0] r_tx_data;
  logic r_tx_start;
  logic [NUM_REQ-1:0] w_elig;
  logic w_found, w_accept, w_to, w_done, w_hold;
`ifdef UART_ARB_LOCK_EN
  logic r_lock;
  assign w_elig = r_lock ? (i_req_valid & (NUM_REQ'(1) << r_grant)) : i_req_valid;
  assign w_hold = r_lock;
`else
  logic w_unused;
  assign w_unused = ^i_req_lock;
  assign w_elig = i_req_valid;
  assign w_hold = 1'b0;
`endif
  assign w_ptr_inc     = (r_grant == PW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
  assign o_tx_data     = r_tx_data;
  assign o_tx_start    = r_tx_start;
  assign o_grant_id    = r_grant;
  assign o_active      = r_state != IDLE;
  assign o_err_timeout = w_to;
  // First eligible requester searching from r_ptr; descending offsets so the nearest wins
  always_comb begin
    int j;
    j = 0;
    w_found = 1'b0;
    w_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(r_ptr) + i) % NUM_REQ;
      if (w_elig[j]) begin
        w_found = 1'b1;
        w_win = PW'(j);
      end
    end
  end
  // Next state and handshake strobes; ready is only offered while idle and the line is free
  always_comb begin
    w_next = r_state;
    w_accept = 1'b0;
    w_to = 1'b0;
    w_done = 1'b0;
    o_req_ready = '0;
    case (r_state)
      IDLE: if (!i_tx_busy && w_found && !i_reset) begin
        o_req_ready = NUM_REQ'(1) << w_win;
        w_accept = 1'b1;
        w_next = LAUNCH;
      end
      LAUNCH: w_next = WAIT_BUSY;
      WAIT_BUSY: if (i_tx_busy) w_next = WAIT_DONE;
        else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          w_to = 1'b1;
          w_next = IDLE;
        end
      WAIT_DONE: if (!i_tx_busy) begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Datapath: captured byte, launch pulse, busy-wait counter and rotation pointer
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= '0;
      r_grant <= '0;
      r_cnt <= '0;
      r_tx_data <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= w_accept;
      r_cnt <= (r_state == WAIT_BUSY) ? r_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_tx_data <= i_req_data[w_win*DATA_W +: DATA_W];
        r_grant <= w_win;
      end
      if (w_to || (w_done && !w_hold)) r_ptr <= w_ptr_inc;
    end
  end
`ifdef UART_ARB_LOCK_EN
  // Lock follows the flag sampled with each accepted byte; a timeout always releases it
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) r_lock <= 1'b0;
    else if (w_to) r_lock <= 1'b0;
    else if (w_accept) r_lock <= i_req_lock[w_win];
  end
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner sequences and randomized traffic against a reference model
module tb_uart_tx_arbiter;
  localparam int N = 4, DW = 8, BT = 16;
  logic clk = 1'b0;
  logic i_reset, o_tx_start, i_tx_busy, o_active, o_err_timeout;
  logic [N-1:0] i_req_valid, i_req_lock, o_req_ready;
  logic [N*DW-1:0] i_req_data;
  logic [DW-1:0] o_tx_data;
  logic [1:0] o_grant_id;
  int n_cmp = 0, n_bad = 0;
  typedef struct {logic [N-1:0] valid; logic busy; logic [N-1:0] ready;} vec_t;
  vec_t tbl [8];

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .i_req_lock(i_req_lock), .o_req_ready(o_req_ready), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy), .o_grant_id(o_grant_id),
    .o_active(o_active), .o_err_timeout(o_err_timeout));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_byte(input int k, input logic [DW-1:0] v);
    i_req_data[k*DW +: DW] = v;
  endtask

  task automatic do_reset;
    i_reset = 1'b1;
    i_req_valid = '0;
    i_req_lock = '0;
    i_req_data = '0;
    i_tx_busy = 1'b0;
    tick;
    tick;
    #1 chk("reset_outs", {o_req_ready, o_tx_data, o_tx_start, o_grant_id, o_active, o_err_timeout}, 0);
    i_reset = 1'b0;
  endtask

  task automatic wait_start(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick;
      #1 seen = o_tx_start;
    end
    chk({nm, "_start"}, 32'(seen), 1);
  endtask

  task automatic serve(input int d, input int len);
    repeat (d) begin tick; i_tx_busy = 1'b0; end
    repeat (len) begin tick; i_tx_busy = 1'b1; end
    tick;
    i_tx_busy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] v, er;
    logic [N*DW-1:0] dat;
    logic [DW-1:0] mdat;
    int acc, idle_at, brise, blen, ptr, w, gid, d, bad;
    bit to, busy;
    tbl[0] = '{4'b0000, 1'b0, 4'b0000};
    tbl[1] = '{4'b0001, 1'b0, 4'b0001};
    tbl[2] = '{4'b0110, 1'b0, 4'b0010};
    tbl[3] = '{4'b1000, 1'b0, 4'b1000};
    tbl[4] = '{4'b1100, 1'b0, 4'b0100};
    tbl[5] = '{4'b1111, 1'b1, 4'b0000};
    tbl[6] = '{4'b1010, 1'b0, 4'b0010};
    tbl[7] = '{4'b1111, 1'b0, 4'b0001};
    do_reset;
    for (int t = 0; t < 8; t++) begin
      tick;
      i_req_valid = tbl[t].valid;
      i_tx_busy = tbl[t].busy;
      #1 chk($sformatf("tbl%0d_ready", t), o_req_ready, tbl[t].ready);
      #1 i_req_valid = '0;
      i_tx_busy = 1'b0;
    end
    // single request
    do_reset;
    tick;
    set_byte(1, 8'h5A);
    i_req_valid = 4'b0010;
    #1 chk("single_ready", o_req_ready, 4'b0010);
    chk("single_nostart", o_tx_start, 0);
    tick;
    i_req_valid = '0;
    #1 chk("single_start", o_tx_start, 1);
    chk("single_data", o_tx_data, 8'h5A);
    chk("single_gid", o_grant_id, 1);
    chk("single_ready_gone", o_req_ready, 0);
    tick;
    i_tx_busy = 1'b1;
    #1 chk("single_pulse_once", o_tx_start, 0);
    repeat (9) tick;
    tick;
    i_tx_busy = 1'b0;
    #1 chk("single_active_tail", o_active, 1);
    tick;
    #1 chk("single_active_drop", o_active, 0);
    // fairness
    do_reset;
    for (int k = 0; k < N; k++) set_byte(k, DW'(8'h10 + k));
    i_req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_start($sformatf("fair%0d", g));
      chk($sformatf("fair%0d_gid", g), o_grant_id, g % N);
      chk($sformatf("fair%0d_data", g), o_tx_data, 8'h10 + g % N);
      serve(1, 2);
    end
    // busy at idle
    do_reset;
    set_byte(0, 8'h66);
    i_tx_busy = 1'b1;
    i_req_valid = 4'b0001;
    bad = 0;
    repeat (20) begin
      tick;
      #1 if (o_req_ready != 0 || o_tx_start) bad++;
    end
    chk("busyidle_quiet", bad, 0);
    tick;
    i_tx_busy = 1'b0;
    #1 chk("busyidle_ready", o_req_ready, 4'b0001);
    wait_start("busyidle");
    i_req_valid = '0;
    chk("busyidle_gid", o_grant_id, 0);
    chk("busyidle_data", o_tx_data, 8'h66);
    serve(0, 1);
    // timeout
    do_reset;
    set_byte(0, 8'hA0);
    set_byte(1, 8'hA1);
    i_req_valid = 4'b0011;
    wait_start("to");
    chk("to_gid", o_grant_id, 0);
    for (int i = 1; i <= BT; i++) begin
      tick;
      #1 chk($sformatf("to_err_c%0d", i), o_err_timeout, i == BT);
    end
    tick;
    #1 chk("to_back_idle", {o_active, o_err_timeout}, 0);
    chk("to_next_ready", o_req_ready, 4'b0010);
    wait_start("to_next");
    i_req_valid = '0;
    chk("to_next_gid", o_grant_id, 1);
    chk("to_next_data", o_tx_data, 8'hA1);
    serve(0, 1);
    // reset in the middle of a frame
    set_byte(2, 8'h77);
    i_req_valid = 4'b0100;
    wait_start("rst");
    i_req_valid = '0;
    tick;
    i_tx_busy = 1'b1;
    tick;
    i_req_valid = 4'b1111;
    #2 i_reset = 1'b1;
    #1 chk("rst_outs", {o_req_ready, o_tx_data, o_tx_start, o_grant_id, o_active, o_err_timeout}, 0);
    tick;
    i_reset = 1'b0;
    bad = 0;
    repeat (3) begin
      tick;
      #1 if (o_tx_start || o_req_ready != 0) bad++;
    end
    chk("rst_no_stray", bad, 0);
    tick;
    i_tx_busy = 1'b0;
    i_req_valid = 4'b1001;
    #1 chk("rst_ptr0_ready", o_req_ready, 4'b0001);
    wait_start("rst_after");
    i_req_valid = '0;
    chk("rst_after_gid", o_grant_id, 0);
    serve(0, 1);
`ifdef UART_ARB_LOCK_EN
    do_reset;
    set_byte(2, 8'h41);
    i_req_lock = 4'b0100;
    i_req_valid = 4'b0100;
    wait_start("lk1");
    chk("lk1_gid", o_grant_id, 2);
    chk("lk1_data", o_tx_data, 8'h41);
    set_byte(0, 8'h30);
    set_byte(3, 8'h33);
    set_byte(2, 8'h42);
    i_req_valid = 4'b1101;
    serve(0, 1);
    wait_start("lk2");
    chk("lk2_gid", o_grant_id, 2);
    chk("lk2_data", o_tx_data, 8'h42);
    set_byte(2, 8'h43);
    i_req_lock = '0;
    serve(0, 1);
    wait_start("lk3");
    chk("lk3_gid", o_grant_id, 2);
    chk("lk3_data", o_tx_data, 8'h43);
    i_req_valid = 4'b1001;
    serve(0, 1);
    wait_start("lk4");
    chk("lk4_gid", o_grant_id, 3);
    chk("lk4_data", o_tx_data, 8'h33);
    i_req_valid = '0;
    serve(0, 1);
`endif
    // randomized traffic: model tracks grant rotation and the busy schedule it drives
    do_reset;
    v = '0;
    dat = '0;
    mdat = '0;
    acc = -100;
    idle_at = 0;
    brise = 0;
    blen = 0;
    ptr = 0;
    w = 0;
    gid = 0;
    to = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      tick;
      busy = !to && n >= brise && n < brise + blen;
      for (int k = 0; k < N; k++) begin
        if (!v[k] && $urandom_range(2) == 0) begin
          v[k] = 1'b1;
          dat[k*DW +: DW] = DW'($urandom);
        end else if (v[k] && $urandom_range(9) == 0) v[k] = 1'b0;
      end
      i_req_valid = v;
      i_req_data = dat;
      i_tx_busy = busy;
      #1 er = '0;
      if (n >= idle_at && !busy)
        for (int o = N - 1; o >= 0; o--)
          if (v[(ptr + o) % N]) begin
            w = (ptr + o) % N;
            er = '0;
            er[w] = 1'b1;
          end
      chk("rnd_ready", o_req_ready, er);
      chk("rnd_start", o_tx_start, n == acc + 1);
      chk("rnd_err", o_err_timeout, to && n == acc + 1 + BT);
      chk("rnd_active", o_active, n < idle_at);
      if (n == acc + 1) begin
        chk("rnd_data", o_tx_data, mdat);
        chk("rnd_gid", o_grant_id, gid);
      end
      if (er != 0) begin
        acc = n;
        gid = w;
        mdat = dat[w*DW +: DW];
        to = $urandom_range(4) == 0;
        d = $urandom_range(5);
        blen = 1 + $urandom_range(5);
        brise = n + 2 + d;
        idle_at = to ? n + 2 + BT : n + 3 + d + blen;
        ptr = (w + 1) % N;
        v[w] = 1'b0;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter between NUM_REQ requesters using round-robin arbitration.
- Accepts one byte per grant through a per-requester valid/ready handshake.
- Launches the byte with a one-cycle start pulse, then tracks the transmitter's busy flag until the frame is complete.
- Sits between on-chip byte producers (status, debug, loopback of received bytes) and the serial TX line driver.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_W, 8, byte width.
- BUSY_TIMEOUT, 16, max cycles to wait for i_tx_busy to rise after a start pulse.

Ports:
- clk  in  1  clock; the only clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester byte valid; must hold with stable data until ready.
- i_req_data  in  NUM_REQ*DATA_W  packed bytes; requester k occupies bits [k*DATA_W +: DATA_W].
- i_req_lock  in  NUM_REQ  per-requester "more bytes follow" flag, sampled with data.
- o_req_ready  out  NUM_REQ  one-hot accept; combinational.
- o_tx_data  out  DATA_W  byte to the transmitter; registered.
- o_tx_start  out  1  one-cycle launch pulse; registered.
- i_tx_busy  in  1  transmitter busy, high while a frame is on the line.
- o_grant_id  out  clog2(NUM_REQ)  index of the last accepted requester.
- o_active  out  1  high whenever state != IDLE.
- o_err_timeout  out  1  one-cycle pulse when busy never rose.

Behaviour:
- Reset state: IDLE.
  - Outputs: o_req_ready=0, o_tx_data=0, o_tx_start=0, o_grant_id=0, o_active=0, o_err_timeout=0.
  - Internal: round-robin pointer r_ptr=0, timeout counter=0, lock state cleared.
  - Reset asserted mid-operation aborts immediately; no start pulse follows.
- IDLE:
  - Grant is eligible only when i_tx_busy=0. This covers a transmitter still busy after reset.
  - Winner is the first valid requester searching r_ptr, r_ptr+1, ... modulo NUM_REQ.
  - o_req_ready[winner]=1 in the same cycle; all other ready bits are 0.
  - The transfer happens on valid&ready. At that edge: o_tx_data<=data[winner], o_grant_id<=winner, go to LAUNCH.
  - No valid requester, or busy=1: stay in IDLE.
- LAUNCH: o_tx_start=1 for exactly one cycle, then go to WAIT_BUSY with counter=0.
- WAIT_BUSY:
  - i_tx_busy=1: go to WAIT_DONE.
  - Otherwise the counter increments. On counter==BUSY_TIMEOUT-1 with busy still low: pulse o_err_timeout, go to IDLE. The byte is dropped and the pointer still advances.
- WAIT_DONE:
  - Stay while i_tx_busy=1.
  - On busy=0: go to IDLE and set r_ptr<=(o_grant_id+1) mod NUM_REQ. Wrap from NUM_REQ-1 goes to 0.
- Latency: valid in IDLE with busy low -> ready in the same cycle -> start pulse 1 cycle later. Minimum spacing between consecutive start pulses is 3 cycles plus the transmitter busy time.
- o_tx_data stays stable from LAUNCH until the next accept.
- o_req_ready is never asserted outside IDLE.
- A requester dropping valid before ready is legal; it simply loses eligibility.
- Simultaneous valid from all requesters: each receives exactly one grant in pointer order before any receives a second.

Optional Feature:
- Macro: UART_ARB_LOCK_EN (message locking).
- With the macro:
  - A byte accepted with i_req_lock[k]=1 locks arbitration to requester k.
  - In IDLE, only k is eligible, and r_ptr does not advance.
  - The lock clears when k transfers a byte with lock=0, or on timeout error. Normal rotation then resumes from k+1.
  - A locked requester that deasserts valid stalls the arbiter in IDLE until it returns.
- Without the macro: i_req_lock is ignored and arbitration is pure per-byte round-robin.

Test Plan:
- Single request: reset, then req1 valid data 0x5A, busy model 10 cycles -> ready[1] pulses once, o_tx_start one cycle later with o_tx_data=0x5A, o_grant_id=1, o_active drops the cycle after busy falls.
- Fairness: all 4 valid continuously, distinct bytes 0x10..0x13 -> start order 0,1,2,3,0 with matching data; no requester is granted twice within 4 grants.
- Busy at idle: i_tx_busy held high 20 cycles after reset while req0 valid -> no ready and no start until busy drops, then normal grant.
- Timeout: transmitter never raises busy -> o_err_timeout pulses exactly BUSY_TIMEOUT cycles after start, state returns to IDLE, next grant goes to the following requester.
- Reset mid-frame: assert i_reset during WAIT_DONE -> all outputs 0 immediately, r_ptr=0, no stray start pulse.
- Lock (UART_ARB_LOCK_EN defined): req2 sends 3 bytes with lock=1,1,0 while req0/req3 are valid -> three consecutive grants to 2, then grant to 3.
